// File: rtl/sar_compare_search.sv
// Successive-approximation search driving comparator A (trial) against an unknown B, MSB first.
// Optional macro CMP_PIPE_EN: registered comparator, present/decide cycle pair per bit.
module sar_compare_search #(
  parameter int word_size = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             lt,
  input  logic                             gt,
  input  logic                             eq,
  output logic [word_size-1:0]             trial,
  output logic                             busy,
  output logic                             done,
  output logic [word_size-1:0]             result,
  output logic                             hit,
  output logic [$clog2(word_size+1)-1:0]   steps,
  output logic                             err
);

  localparam int IW = $clog2(word_size);
  localparam int SW = $clog2(word_size + 1);
  localparam logic [word_size-1:0] ONE = word_size'(1);
  localparam logic [word_size-1:0] MSB = ONE << (word_size - 1);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t              state, state_next;
  logic [IW-1:0]       idx, idx_next;
  logic [word_size-1:0] acc, acc_next, trial_next, result_next;
  logic [SW-1:0]       count, count_next, steps_next;
  logic                hit_next, err_next, done_next;
  logic [word_size-1:0] bit_idx, acc_new;
  logic [SW-1:0]       count_inc;
  logic                legal, decide;
`ifdef CMP_PIPE_EN
  logic                phase, phase_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      trial  <= '0;
      count  <= '0;
      result <= '0;
      hit    <= 1'b0;
      steps  <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
`ifdef CMP_PIPE_EN
      phase  <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      acc    <= acc_next;
      trial  <= trial_next;
      count  <= count_next;
      result <= result_next;
      hit    <= hit_next;
      steps  <= steps_next;
      err    <= err_next;
      done   <= done_next;
`ifdef CMP_PIPE_EN
      phase  <= phase_next;
`endif
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    acc_next    = acc;
    trial_next  = trial;
    count_next  = count;
    result_next = result;
    hit_next    = hit;
    steps_next  = steps;
    err_next    = err;
    done_next   = 1'b0;
`ifdef CMP_PIPE_EN
    phase_next  = phase;
    decide      = phase;
`else
    decide      = 1'b1;
`endif
    bit_idx   = ONE << idx;
    acc_new   = lt ? (acc | bit_idx) : (acc & ~bit_idx);
    count_inc = count + SW'(1);
    // exactly one flag: odd parity but not all three
    legal     = (lt ^ gt ^ eq) & ~(lt & gt & eq);

    case (state)
      IDLE: begin
        // done is still high on the completion cycle; a start there is dropped
        if (start && !done) begin
          state_next = SEARCH;
          idx_next   = IW'(word_size - 1);
          acc_next   = '0;
          trial_next = MSB;
          count_next = '0;
          err_next   = 1'b0;
          hit_next   = 1'b0;
          steps_next = '0;
`ifdef CMP_PIPE_EN
          phase_next = 1'b0;
`endif
        end
      end
      SEARCH: begin
`ifdef CMP_PIPE_EN
        phase_next = ~phase;
`endif
        if (decide) begin
          count_next = count_inc;
          if (!legal) begin
            err_next    = 1'b1;
            result_next = '0;
            hit_next    = 1'b0;
            done_next   = 1'b1;
            steps_next  = count_inc;
            state_next  = IDLE;
          end else if (eq) begin
            result_next = trial;
            hit_next    = 1'b1;
            done_next   = 1'b1;
            steps_next  = count_inc;
            state_next  = IDLE;
          end else begin
            acc_next = acc_new;
            if (idx == '0) begin
              result_next = acc_new;
              hit_next    = 1'b0;
              done_next   = 1'b1;
              steps_next  = count_inc;
              state_next  = IDLE;
            end else begin
              idx_next   = idx - IW'(1);
              trial_next = acc_new | (ONE << (idx - IW'(1)));
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SEARCH);
  end

endmodule

// File: tb/tb_sar_compare_search.sv
// Directed bench for sar_compare_search with a behavioural comparator on the trial output.
module tb_sar_compare_search;

`ifdef CMP_PIPE_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif
  localparam int LIMIT = 2 * 16 + 6;

  logic        clk = 1'b0;
  logic        rst, start, lt, gt, eq, busy, done, hit, err, force_ill;
  logic [15:0] trial, result, target;
  logic [4:0]  steps;
  int tests = 0;
  int fails = 0;

  sar_compare_search #(.word_size(16)) dut (
    .clk(clk), .rst(rst), .start(start), .lt(lt), .gt(gt), .eq(eq),
    .trial(trial), .busy(busy), .done(done), .result(result),
    .hit(hit), .steps(steps), .err(err)
  );

  always #5 clk = ~clk;

  assign lt = force_ill | (trial < target);
  assign gt = force_ill | (trial > target);
  assign eq = !force_ill && (trial == target);

  // Starts from an idle cycle; returns on the negedge of the done cycle.
  task automatic run_search(input logic [15:0] tgt, input bit pulse_extra, input int force_at,
                            input bit check_ones, output int done_cyc, output logic [15:0] last_trial);
    logic [15:0] exp_trial;
    @(negedge clk);
    target = tgt;
    start = 1'b1;
    done_cyc = -1;
    last_trial = '0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (n == 1) begin
        tests++;
        if (busy !== 1'b1 || err !== 1'b0 || trial !== 16'h8000) begin
          fails++;
          $display("FAIL first_cycle: busy=%b err=%b trial=%h, want busy=1 err=0 trial=8000", busy, err, trial);
        end
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      if (check_ones && (n % K == 0)) begin
        exp_trial = 16'hFFFF << (16 - n / K);
        tests++;
        if (trial !== exp_trial) begin
          fails++;
          $display("FAIL ones_trial d=%0d: got %h want %h", n / K, trial, exp_trial);
        end
      end
      last_trial = trial;
      start = pulse_extra && (n == 3 || n == 5);
      force_ill = (force_at > 0) && (n == force_at * K);
    end
    start = 1'b0;
    force_ill = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; force_ill = 1'b0; target = 16'h0;
    repeat (3) @(negedge clk);
    tests++;
    if (trial !== 0 || result !== 0 || steps !== 0 || busy !== 0 || done !== 0 || hit !== 0 || err !== 0) begin
      fails++;
      $display("FAIL reset: trial=%h result=%h steps=%0d busy=%b done=%b hit=%b err=%b, want all 0",
               trial, result, steps, busy, done, hit, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_msb_match();
    int dc; logic [15:0] lt_tr;
    run_search(16'h8000, 0, 0, 0, dc, lt_tr);
    tests++;
    if (dc !== K + 1 || result !== 16'h8000 || hit !== 1'b1 || steps !== 5'd1 || err !== 1'b0) begin
      fails++;
      $display("FAIL msb_match: cyc=%0d result=%h hit=%b steps=%0d err=%b, want cyc=%0d 8000 1 1 0",
               dc, result, hit, steps, err, K + 1);
    end
  endtask

  task automatic test_all_ones();
    int dc; logic [15:0] lt_tr;
    run_search(16'hFFFF, 0, 0, 1, dc, lt_tr);
    tests++;
    if (dc !== 16 * K + 1 || result !== 16'hFFFF || hit !== 1'b1 || steps !== 5'd16) begin
      fails++;
      $display("FAIL all_ones: cyc=%0d result=%h hit=%b steps=%0d, want cyc=%0d FFFF 1 16",
               dc, result, hit, steps, 16 * K + 1);
    end
  endtask

  task automatic test_zero_target();
    int dc; logic [15:0] lt_tr;
    run_search(16'h0000, 0, 0, 0, dc, lt_tr);
    tests++;
    if (dc !== 16 * K + 1 || result !== 16'h0 || hit !== 1'b0 || steps !== 5'd16 || err !== 1'b0) begin
      fails++;
      $display("FAIL zero_target: cyc=%0d result=%h hit=%b steps=%0d err=%b, want cyc=%0d 0000 0 16 0",
               dc, result, hit, steps, err, 16 * K + 1);
    end
    tests++;
    if (lt_tr !== 16'h0001) begin
      fails++;
      $display("FAIL zero_last_trial: got %h want 0001", lt_tr);
    end
  endtask

  task automatic test_start_while_busy();
    int dc; int extra; logic [15:0] lt_tr;
    run_search(16'h1234, 1, 0, 0, dc, lt_tr);
    tests++;
    if (dc !== 14 * K + 1 || result !== 16'h1234 || hit !== 1'b1 || steps !== 5'd14) begin
      fails++;
      $display("FAIL busy_start: cyc=%0d result=%h hit=%b steps=%0d, want cyc=%0d 1234 1 14",
               dc, result, hit, steps, 14 * K + 1);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL busy_start_single_done: %0d extra active cycles, want 0", extra);
    end
  endtask

  task automatic test_illegal_flags();
    int dc; logic [15:0] lt_tr;
    run_search(16'h1234, 0, 3, 0, dc, lt_tr);
    tests++;
    if (dc !== 3 * K + 1 || err !== 1'b1 || result !== 16'h0 || hit !== 1'b0 || steps !== 5'd3) begin
      fails++;
      $display("FAIL illegal: cyc=%0d err=%b result=%h hit=%b steps=%0d, want cyc=%0d 1 0000 0 3",
               dc, err, result, hit, steps, 3 * K + 1);
    end
    run_search(16'h00FF, 0, 0, 0, dc, lt_tr);
    tests++;
    if (err !== 1'b0 || result !== 16'h00FF || hit !== 1'b1 || steps !== 5'd16) begin
      fails++;
      $display("FAIL illegal_recover: err=%b result=%h hit=%b steps=%0d, want 0 00FF 1 16",
               err, result, hit, steps);
    end
  endtask

  task automatic test_mid_reset();
    int dc; int seen; logic [15:0] lt_tr;
    @(negedge clk);
    target = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (trial !== 0 || result !== 0 || steps !== 0 || busy !== 0 || done !== 0 || hit !== 0 || err !== 0) begin
      fails++;
      $display("FAIL mid_reset: trial=%h result=%h steps=%0d busy=%b done=%b hit=%b err=%b, want all 0",
               trial, result, steps, busy, done, hit, err);
    end
    seen = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL mid_reset_no_done: %0d done pulses, want 0", seen);
    end
    run_search(16'h8000, 0, 0, 0, dc, lt_tr);
    tests++;
    if (dc !== K + 1 || result !== 16'h8000 || hit !== 1'b1 || steps !== 5'd1) begin
      fails++;
      $display("FAIL mid_reset_clean: cyc=%0d result=%h hit=%b steps=%0d, want cyc=%0d 8000 1 1",
               dc, result, hit, steps, K + 1);
    end
  endtask

  task automatic test_back_to_back();
    int dc; logic [15:0] lt_tr;
    run_search(16'h8000, 0, 0, 0, dc, lt_tr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || trial !== 16'h8000) begin
      fails++;
      $display("FAIL done_cycle_start: busy=%b done=%b trial=%h, want busy=0 done=0 trial=8000",
               busy, done, trial);
    end
    run_search(16'h0001, 0, 0, 0, dc, lt_tr);
    tests++;
    if (dc !== 16 * K + 1 || result !== 16'h0001 || hit !== 1'b1 || steps !== 5'd16) begin
      fails++;
      $display("FAIL back_to_back: cyc=%0d result=%h hit=%b steps=%0d, want cyc=%0d 0001 1 16",
               dc, result, hit, steps, 16 * K + 1);
    end
    @(negedge clk);
    tests++;
    if (result !== 16'h0001 || done !== 1'b0) begin
      fails++;
      $display("FAIL result_hold: result=%h done=%b, want 0001 0", result, done);
    end
  endtask

  initial begin
    test_reset();
    test_msb_match();
    test_all_ones();
    test_zero_target();
    test_start_while_busy();
    test_illegal_flags();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
